alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter M_DELAY, default 2, cycles from the operand-A/start cycle to the first operand-M cycle (legal range 1-15).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles allowed before alu_finish (legal range 2-255).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  operation request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have ports req_x and req_y  input  8 each  operands; X goes to the ALU A register, Y to the M register.
REQ-009 SHALL have port alu_start  output  1  start pulse to the ALU.
REQ-010 SHALL have port alu_sel  output  2  ALU operation select.
REQ-011 SHALL have port alu_inbus  output  8  ALU operand bus.
REQ-012 SHALL have port alu_outbus  input  8  ALU result bus.
REQ-013 SHALL have port alu_finish  input  1  ALU completion flag.
REQ-014 SHALL have port rsp_valid  output  1  response available.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-016 SHALL have ports rsp_data  output  16, rsp_op  output  2 and rsp_err  output  1: result, echoed op and timeout flag.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, LOAD_A, LOAD_M, WAIT, CAP_HI and RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE, and SHALL latch req_op, req_x and req_y on the req_valid&req_ready cycle, then enter LOAD_A.
REQ-020 SHALL, in LOAD_A (exactly 1 cycle), drive alu_start=1, alu_sel=op and alu_inbus=X.
REQ-021 SHALL hold alu_inbus=X with alu_start=0 for the next M_DELAY-1 cycles, then enter LOAD_M.
REQ-022 SHALL, in LOAD_M and WAIT, drive alu_inbus=Y until the final capture, and SHALL hold alu_sel=op from LOAD_A until leaving WAIT/CAP_HI.
REQ-023 SHALL enter WAIT one cycle after LOAD_M and SHALL ignore alu_finish in every state except WAIT.
REQ-024 SHALL, on alu_finish=1 in WAIT, capture alu_outbus into rsp_data[7:0].
REQ-025 SHALL, for add/sub, clear rsp_data[15:8] to 0 and enter RESP on that finish cycle.
REQ-026 SHALL, for mul/div, enter CAP_HI and capture alu_outbus into rsp_data[15:8] on the following cycle, then enter RESP.
REQ-027 SHALL form mul as {A,Q} and div as {remainder,quotient} from that byte order.
REQ-028 SHALL count WAIT cycles with an 8-bit counter cleared on WAIT entry.
REQ-029 SHALL, if the count reaches TIMEOUT without alu_finish, enter RESP with rsp_err=1 and rsp_data=16'h0000.
REQ-030 SHALL give alu_finish precedence when it arrives on the timeout cycle itself.
REQ-031 SHALL, in RESP, assert rsp_valid with rsp_data, rsp_op and rsp_err stable until rsp_valid&rsp_ready, then return to IDLE on the next cycle.
REQ-032 SHALL leave a back-to-back request unaccepted until the cycle after the response handshake (no overlap), which makes minimum request-to-response latency 1+M_DELAY+1+finish_wait cycles (+1 for mul/div).
REQ-033 SHALL keep alu_start=0, alu_inbus=0 and alu_sel=0 in IDLE and RESP.
REQ-034 SHALL treat alu_outbus as don't-care outside capture cycles.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, enter IDLE from any state (including mid-WAIT or RESP) and drop any in-flight operation silently.
REQ-036 SHALL hold these reset values: req_ready=1 from the cycle after reset, alu_start=0, alu_sel=0, alu_inbus=0, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, busy=0, WAIT counter=0.
REQ-037 SHALL take priority for rst over any simultaneous req_valid, alu_finish or rsp_ready.

Verification
REQ-038 SHALL verify add: op=00, X=40, Y=12, finish 5 cycles after LOAD_M -> alu_start high one cycle with inbus=40, inbus=12 two cycles later, rsp_data=16'h0034, rsp_err=0.
REQ-039 SHALL verify mul: op=10, X=12, Y=10, alu_outbus=8'h78 then 8'h00 -> rsp_data=16'h0078, rsp_op=10.
REQ-040 SHALL verify backpressure: rsp_ready low 6 cycles -> rsp_valid and rsp_data constant, req_ready=0 and a new req_valid not accepted until after the handshake.
REQ-041 SHALL verify timeout: TIMEOUT=8, no finish -> RESP after 8 WAIT cycles with rsp_err=1 and rsp_data=0; and finish exactly on cycle 8 -> normal result.
REQ-042 SHALL verify reset mid-WAIT: rst pulsed during WAIT -> next cycle all outputs at reset values; a later finish pulse is ignored and no response is produced.
REQ-043 SHALL verify a spurious alu_finish in IDLE or LOAD_A -> no capture and no state change.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, sequences the operand
// loads and start pulse into a multi-cycle ALU, captures the 8- or 16-bit
// result, and presents it on a valid/ready response port. A WAIT-cycle
// counter bounds how long it waits for alu_finish.
module alu_sequencer #(
    parameter int M_DELAY = 2,   // cycles from the A/start cycle to the first M cycle (1-15)
    parameter int TIMEOUT = 64   // max WAIT cycles before giving up (2-255)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    output logic        alu_start,
    output logic [1:0]  alu_sel,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_finish,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    // HOLD_A is the X-hold phase between the one-cycle LOAD_A start and LOAD_M;
    // it only exists when M_DELAY > 1.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        HOLD_A = 3'd2,
        LOAD_M = 3'd3,
        WAIT   = 3'd4,
        CAP_HI = 3'd5,
        RESP   = 3'd6
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'((M_DELAY >= 2) ? (M_DELAY - 2) : 0);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [3:0]  dly_q, dly_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] data_q, data_d;
    logic        err_q, err_d;

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            dly_q   <= 4'd0;
            wcnt_q  <= 8'd0;
            data_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dly_q   <= dly_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and ALU-side outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        dly_d     = dly_q;
        wcnt_d    = wcnt_q;
        data_d    = data_q;
        err_d     = err_q;
        alu_start = 1'b0;
        alu_sel   = 2'd0;
        alu_inbus = 8'd0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    x_d     = req_x;
                    y_d     = req_y;
                    data_d  = 16'd0;
                    err_d   = 1'b0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                alu_start = 1'b1;
                alu_sel   = op_q;
                alu_inbus = x_q;
                dly_d     = 4'd0;
                state_d   = (M_DELAY == 1) ? LOAD_M : HOLD_A;
            end
            HOLD_A: begin
                alu_sel   = op_q;
                alu_inbus = x_q;
                dly_d     = dly_q + 4'd1;
                if (dly_q == HOLD_LAST) state_d = LOAD_M;
            end
            LOAD_M: begin
                alu_sel   = op_q;
                alu_inbus = y_q;
                wcnt_d    = 8'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                alu_sel   = op_q;
                alu_inbus = y_q;
                wcnt_d    = wcnt_q + 8'd1;
                // finish wins over a timeout landing on the same cycle
                if (alu_finish) begin
                    data_d  = {8'd0, alu_outbus};
                    state_d = op_q[1] ? CAP_HI : RESP;
                end else if (wcnt_q == WAIT_LAST) begin
                    data_d  = 16'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            CAP_HI: begin
                // second byte: A for mul, remainder for div
                alu_sel      = op_q;
                alu_inbus    = y_q;
                data_d[15:8] = alu_outbus;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_op    = op_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (M_DELAY=2, TIMEOUT=8).
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_x, req_y;
    logic        alu_start;
    logic [1:0]  alu_sel;
    logic [7:0]  alu_inbus, alu_outbus;
    logic        alu_finish;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_err, busy;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.M_DELAY(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .alu_start(alu_start), .alu_sel(alu_sel), .alu_inbus(alu_inbus),
        .alu_outbus(alu_outbus), .alu_finish(alu_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".vld"},   32'(rsp_valid), 32'd0);
        chk({tag, ".alu"},   {21'd0, alu_start, alu_sel, alu_inbus}, 32'd0);
    endtask

    task automatic to_wait(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        tick();                      // LOAD_A
        req_valid = 1'b0;
        tick();                      // hold X
        tick();                      // LOAD_M
        tick();                      // WAIT, count 0
    endtask

    initial begin
        logic [15:0] held;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_x = 8'd0; req_y = 8'd0;
        alu_outbus = 8'd0; alu_finish = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_idle_outs("reset");
        chk("reset.data", {14'd0, rsp_err, rsp_op, rsp_data}, 32'd0);

        // spurious finish in IDLE
        alu_finish = 1'b1; alu_outbus = 8'hAA;
        tick();
        alu_finish = 1'b0;
        chk_idle_outs("idle_fin");
        chk("idle_fin.data", 32'(rsp_data), 32'd0);

        // add 40+12, finish 5 cycles after LOAD_M
        req_valid = 1'b1; req_op = 2'b00; req_x = 8'd40; req_y = 8'd12;
        tick();
        req_valid = 1'b0;
        chk("add.start", 32'(alu_start), 32'd1);
        chk("add.inA",   32'(alu_inbus), 32'd40);
        chk("add.busy",  {30'd0, busy, req_ready}, 32'b10);
        alu_finish = 1'b1; alu_outbus = 8'hAA;   // spurious in LOAD_A
        tick();
        alu_finish = 1'b0;
        chk("add.hold", {23'd0, alu_start, alu_inbus}, 32'd40);
        tick();
        chk("add.inM", 32'(alu_inbus), 32'd12);
        chk("add.sel", 32'(alu_sel), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("add.wait", {22'd0, rsp_valid, busy, alu_inbus}, {22'd0, 1'b0, 1'b1, 8'd12});
        tick();                                    // LOAD_M + 5
        alu_finish = 1'b1; alu_outbus = 8'h34;
        tick();
        alu_finish = 1'b0; alu_outbus = 8'hEE;
        chk("add.vld",  32'(rsp_valid), 32'd1);
        chk("add.data", 32'(rsp_data), 32'h0034);
        chk("add.err",  32'(rsp_err), 32'd0);
        chk("add.alu0", {21'd0, alu_start, alu_sel, alu_inbus}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_idle_outs("add.done");

        // mul 12*10: low byte then high byte
        to_wait(2'b10, 8'd12, 8'd10);
        alu_finish = 1'b1; alu_outbus = 8'h78;
        tick();                                    // CAP_HI
        alu_finish = 1'b0; alu_outbus = 8'h00;
        chk("mul.caphi", {21'd0, rsp_valid, alu_sel, alu_inbus}, {21'd0, 1'b0, 2'b10, 8'd10});
        tick();
        alu_outbus = 8'h55;
        chk("mul.data", 32'(rsp_data), 32'h0078);
        chk("mul.op",   32'(rsp_op), 32'd2);

        // backpressure with a pending new request
        held = rsp_data;
        req_valid = 1'b1; req_op = 2'b01; req_x = 8'd5; req_y = 8'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp.hold", {13'd0, rsp_valid, req_ready, rsp_err, rsp_data}, {13'd0, 1'b1, 1'b0, 1'b0, held});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp.accept_rdy", {30'd0, req_ready, busy}, 32'b10);

        // timeout: the pending sub request gets no finish
        tick(); req_valid = 1'b0;                  // LOAD_A
        tick(); tick(); tick();                    // hold, LOAD_M, WAIT cnt 0
        for (int i = 0; i < 7; i++) tick();        // WAIT cnt 7
        chk("to.still_wait", 32'(rsp_valid), 32'd0);
        tick();
        chk("to.resp", {13'd0, rsp_valid, rsp_err, rsp_op, rsp_data}, {13'd0, 1'b1, 1'b1, 2'b01, 16'h0000});
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // finish exactly on the 8th WAIT cycle wins over timeout
        to_wait(2'b01, 8'd9, 8'd4);
        for (int i = 0; i < 7; i++) tick();
        alu_finish = 1'b1; alu_outbus = 8'h05;
        tick();
        alu_finish = 1'b0;
        chk("to8.resp", {13'd0, rsp_valid, rsp_err, rsp_op, rsp_data}, {13'd0, 1'b1, 1'b0, 2'b01, 16'h0005});
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // div: low byte quotient, high byte remainder
        to_wait(2'b11, 8'd100, 8'd7);
        alu_finish = 1'b1; alu_outbus = 8'd14;
        tick();
        alu_finish = 1'b0; alu_outbus = 8'd2;
        tick();
        chk("div.data", 32'(rsp_data), 32'h020E);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // reset mid-WAIT, later finish ignored
        to_wait(2'b00, 8'd1, 8'd2);
        tick(); tick();
        rst = 1'b1; alu_finish = 1'b1; rsp_ready = 1'b1;
        tick();
        rst = 1'b0; rsp_ready = 1'b0; alu_outbus = 8'h99;
        chk_idle_outs("rstw");
        chk("rstw.data", {14'd0, rsp_err, rsp_op, rsp_data}, 32'd0);
        tick();
        alu_finish = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_idle_outs("rstw.after");
        chk("rstw.after_data", 32'(rsp_data), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
